// File: rtl/mcu_rst_pkg.sv
// Shared types and constants for the MCU reset-request generator.
// Holds the sequencer states, the request kind and the rst_cause bit positions.
package mcu_rst_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } rst_state_e;

  typedef enum logic {
    CORE = 1'b0,
    SYS  = 1'b1
  } rst_kind_e;

  localparam int CAUSE_CORE_SW = 0;
  localparam int CAUSE_SYS_SW  = 1;
  localparam int CAUSE_WDT     = 2;
  localparam int CAUSE_BTN     = 3;

  // Bit 0 of the request drives the core reset, bit 1 drives the system reset.
  function automatic logic [1:0] kind_to_req(input rst_kind_e kind);
    logic [1:0] req;
    if (kind == SYS) begin
      req = 2'b10;
    end else begin
      req = 2'b01;
    end
    return req;
  endfunction

endpackage

// File: rtl/mcu_rst_req_gen_if.sv
// Request/status bundle between the CPU-side logic and the reset-request generator.
// The master side raises requests and services the watchdog; the slave side is the generator.
interface mcu_rst_req_gen_if;
  import mcu_rst_pkg::*;

  logic [1:0] cpu_soft_rst_req;
  logic       btn_rst_n;
  logic       wdt_en;
  logic       wdt_kick;
  logic       cause_clr;
  logic [1:0] soft_rst_out;
  logic [3:0] rst_cause;
  logic       req_busy;

  modport master (
    output cpu_soft_rst_req,
    output btn_rst_n,
    output wdt_en,
    output wdt_kick,
    output cause_clr,
    input  soft_rst_out,
    input  rst_cause,
    input  req_busy
  );

  modport slave (
    input  cpu_soft_rst_req,
    input  btn_rst_n,
    input  wdt_en,
    input  wdt_kick,
    input  cause_clr,
    output soft_rst_out,
    output rst_cause,
    output req_busy
  );

endinterface

// File: rtl/mcu_rst_btn_debounce.sv
// Button synchronizer and debouncer: emits one single-cycle press_pulse per stable press.
// A new pulse needs the synchronized button to be seen released first.
module mcu_rst_btn_debounce #(
  parameter int DEBOUNCE_LEN = 1000
) (
  input  logic sys_clk,
  input  logic mcu_rst_signal,
  input  logic btn_rst_n,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_LEN > 2) ? $clog2(DEBOUNCE_LEN) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LEN - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic          armed_r;
  logic          press_r;

  // Two-flop synchronizer; idles high so reset looks like a released button.
  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= btn_rst_n;
      sync2_r <= sync1_r;
    end
  end

  // Low-time counter with a one-shot that re-arms only on a released sample.
  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      cnt_r   <= CNT_ZERO;
      armed_r <= 1'b1;
      press_r <= 1'b0;
    end else if (sync2_r) begin
      cnt_r   <= CNT_ZERO;
      armed_r <= 1'b1;
      press_r <= 1'b0;
    end else if (armed_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r   <= cnt_r;
        armed_r <= 1'b0;
        press_r <= 1'b1;
      end else begin
        cnt_r   <= cnt_r + CNT_ONE;
        armed_r <= 1'b1;
        press_r <= 1'b0;
      end
    end else begin
      cnt_r   <= cnt_r;
      armed_r <= 1'b0;
      press_r <= 1'b0;
    end
  end

  assign press_pulse = press_r;

endmodule

// File: rtl/mcu_rst_req_gen.sv
// Reset-request generator: merges CPU, button and watchdog sources into fixed-length
// soft-reset pulses for the MCU reset block and keeps a sticky record of the cause.
module mcu_rst_req_gen
  import mcu_rst_pkg::*;
#(
  parameter int PULSE_LEN    = 4,
  parameter int HOLDOFF_LEN  = 16,
  parameter int DEBOUNCE_LEN = 1000,
  parameter int WDT_TIMEOUT  = 65536
) (
  input logic              sys_clk,
  input logic              mcu_rst_signal,
  mcu_rst_req_gen_if.slave rst_if
);

  localparam int SEQ_MAX = (PULSE_LEN > HOLDOFF_LEN) ? PULSE_LEN : HOLDOFF_LEN;
  localparam int SCW     = (SEQ_MAX > 2) ? $clog2(SEQ_MAX) : 1;
  localparam int WCW     = (WDT_TIMEOUT > 2) ? $clog2(WDT_TIMEOUT) : 1;

  localparam logic [SCW-1:0] SEQ_ZERO     = {SCW{1'b0}};
  localparam logic [SCW-1:0] SEQ_ONE      = SCW'(1);
  localparam logic [SCW-1:0] PULSE_LAST   = SCW'(PULSE_LEN - 1);
  localparam logic [SCW-1:0] HOLDOFF_LAST = SCW'(HOLDOFF_LEN - 1);
  localparam logic [WCW-1:0] WDT_ZERO     = {WCW{1'b0}};
  localparam logic [WCW-1:0] WDT_ONE      = WCW'(1);
  localparam logic [WCW-1:0] WDT_LOAD     = WCW'(WDT_TIMEOUT - 1);

  logic [1:0]     cpu_prev_r;
  logic [1:0]     cpu_edge_s;
  logic           btn_press_s;
  logic [WCW-1:0] wdt_cnt_r;
  logic           wdt_armed_r;
  logic           wdt_expire_s;
  logic           set_core_s;
  logic           set_sys_s;
  logic           take_sys_s;
  logic           take_core_s;
  logic [3:0]     cause_set_s;
  logic           pend_core_r;
  logic           pend_sys_r;
  rst_state_e     state_r;
  rst_kind_e      kind_r;
  logic [SCW-1:0] seq_cnt_r;
  logic [1:0]     soft_rst_out_r;
  logic           req_busy_r;
  logic [3:0]     rst_cause_r;

  mcu_rst_btn_debounce #(
    .DEBOUNCE_LEN (DEBOUNCE_LEN)
  ) u_btn_debounce (
    .sys_clk        (sys_clk),
    .mcu_rst_signal (mcu_rst_signal),
    .btn_rst_n      (rst_if.btn_rst_n),
    .press_pulse    (btn_press_s)
  );

  // History of the CPU request levels for rising-edge detection.
  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      cpu_prev_r <= 2'b00;
    end else begin
      cpu_prev_r <= rst_if.cpu_soft_rst_req;
    end
  end

  assign cpu_edge_s = rst_if.cpu_soft_rst_req & ~cpu_prev_r;

  // A kick on the expiry cycle reloads instead of firing.
  assign wdt_expire_s = rst_if.wdt_en & wdt_armed_r & (wdt_cnt_r == WDT_ZERO) & ~rst_if.wdt_kick;

  // Watchdog down-counter; freezes after expiry until the enable is dropped.
  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      wdt_cnt_r   <= WDT_ZERO;
      wdt_armed_r <= 1'b0;
    end else if (!rst_if.wdt_en) begin
      wdt_cnt_r   <= WDT_LOAD;
      wdt_armed_r <= 1'b1;
    end else if (!wdt_armed_r) begin
      wdt_cnt_r   <= wdt_cnt_r;
      wdt_armed_r <= 1'b0;
    end else if (rst_if.wdt_kick) begin
      wdt_cnt_r   <= WDT_LOAD;
      wdt_armed_r <= 1'b1;
    end else if (wdt_cnt_r == WDT_ZERO) begin
      wdt_cnt_r   <= wdt_cnt_r;
      wdt_armed_r <= 1'b0;
    end else begin
      wdt_cnt_r   <= wdt_cnt_r - WDT_ONE;
      wdt_armed_r <= 1'b1;
    end
  end

  // Event decode shared by the pend flags and the cause register.
  always_comb begin
    set_core_s  = cpu_edge_s[0];
    set_sys_s   = cpu_edge_s[1] | btn_press_s | wdt_expire_s;
    take_sys_s  = (state_r == IDLE) & pend_sys_r;
    take_core_s = (state_r == IDLE) & ~pend_sys_r & pend_core_r;
    cause_set_s = 4'b0000;
    cause_set_s[CAUSE_CORE_SW] = cpu_edge_s[0];
    cause_set_s[CAUSE_SYS_SW]  = cpu_edge_s[1];
    cause_set_s[CAUSE_WDT]     = wdt_expire_s;
    cause_set_s[CAUSE_BTN]     = btn_press_s;
  end

  // Sticky cause bits; a new cause beats a simultaneous clear.
  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      rst_cause_r <= 4'b0000;
    end else begin
      rst_cause_r <= (rst_cause_r & ~{4{rst_if.cause_clr}}) | cause_set_s;
    end
  end

  // Request sequencer with its pend flags and registered pulse outputs.
  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      state_r        <= IDLE;
      kind_r         <= CORE;
      seq_cnt_r      <= SEQ_ZERO;
      pend_core_r    <= 1'b0;
      pend_sys_r     <= 1'b0;
      soft_rst_out_r <= 2'b00;
      req_busy_r     <= 1'b0;
    end else begin
      // A system reset subsumes any pending core reset.
      pend_sys_r     <= set_sys_s | (pend_sys_r & ~take_sys_s);
      pend_core_r    <= set_core_s | (pend_core_r & ~(take_sys_s | take_core_s));
      soft_rst_out_r <= (state_r == ASSERT) ? kind_to_req(kind_r) : 2'b00;
      req_busy_r     <= (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (pend_sys_r) begin
            state_r   <= ASSERT;
            kind_r    <= SYS;
            seq_cnt_r <= PULSE_LAST;
          end else if (pend_core_r) begin
            state_r   <= ASSERT;
            kind_r    <= CORE;
            seq_cnt_r <= PULSE_LAST;
          end else begin
            state_r   <= IDLE;
            kind_r    <= kind_r;
            seq_cnt_r <= SEQ_ZERO;
          end
        end
        ASSERT: begin
          if (seq_cnt_r == SEQ_ZERO) begin
            state_r   <= HOLDOFF;
            seq_cnt_r <= HOLDOFF_LAST;
          end else begin
            state_r   <= ASSERT;
            seq_cnt_r <= seq_cnt_r - SEQ_ONE;
          end
        end
        HOLDOFF: begin
          if (seq_cnt_r == SEQ_ZERO) begin
            state_r   <= IDLE;
            seq_cnt_r <= SEQ_ZERO;
          end else begin
            state_r   <= HOLDOFF;
            seq_cnt_r <= seq_cnt_r - SEQ_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          kind_r    <= CORE;
          seq_cnt_r <= SEQ_ZERO;
        end
      endcase
    end
  end

  assign rst_if.soft_rst_out = soft_rst_out_r;
  assign rst_if.rst_cause    = rst_cause_r;
  assign rst_if.req_busy     = req_busy_r;

endmodule

// File: tb/tb_mcu_rst_req_gen.sv
// Directed bench for mcu_rst_req_gen with short parameters and hand-computed expectations.
module tb_mcu_rst_req_gen;

  logic sys_clk = 1'b0;
  logic mcu_rst_signal;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc;
  logic saw_pulse;

  mcu_rst_req_gen_if rst_if ();

  mcu_rst_req_gen #(
    .PULSE_LEN    (4),
    .HOLDOFF_LEN  (8),
    .DEBOUNCE_LEN (5),
    .WDT_TIMEOUT  (20)
  ) dut (
    .sys_clk        (sys_clk),
    .mcu_rst_signal (mcu_rst_signal),
    .rst_if         (rst_if)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Ticks until soft_rst_out is non-zero; n is the tick count, or -1 on no pulse.
  task automatic wait_pulse(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (rst_if.soft_rst_out != 2'b00) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (rst_if.req_busy && i < 50) begin
      tick();
      i++;
    end
    check_eq(tag, 32'(rst_if.req_busy), 32'd0);
  endtask

  // Called just after edge first-1; checks edges first..last against a pulse starting at edge start.
  task automatic check_window(input string tag, input logic [1:0] kind, input int first,
                              input int last, input int start, input bit chk_busy);
    logic [31:0] exp_out;
    logic [31:0] exp_busy;
    for (int e = first; e <= last; e++) begin
      tick();
      exp_out  = (e >= start && e < start + 4)  ? {30'd0, kind} : 32'd0;
      exp_busy = (e >= start && e < start + 12) ? 32'd1 : 32'd0;
      check_eq({tag, "_out"}, 32'(rst_if.soft_rst_out), exp_out);
      if (chk_busy) begin
        check_eq({tag, "_busy"}, 32'(rst_if.req_busy), exp_busy);
      end
    end
  endtask

  task automatic clear_cause();
    rst_if.cause_clr = 1'b1;
    tick();
    rst_if.cause_clr = 1'b0;
    check_eq("cause_clr", 32'(rst_if.rst_cause), 32'd0);
  endtask

  initial begin
    mcu_rst_signal          = 1'b0;
    rst_if.cpu_soft_rst_req = 2'b00;
    rst_if.btn_rst_n        = 1'b1;
    rst_if.wdt_en           = 1'b0;
    rst_if.wdt_kick         = 1'b0;
    rst_if.cause_clr        = 1'b0;
    repeat (3) tick();
    check_eq("rst_out",   32'(rst_if.soft_rst_out), 32'd0);
    check_eq("rst_cause", 32'(rst_if.rst_cause),    32'd0);
    check_eq("rst_busy",  32'(rst_if.req_busy),     32'd0);
    @(negedge sys_clk);
    mcu_rst_signal = 1'b1;
    tick();
    tick();

    // Core request held high: one 01 pulse on edges 2..5, busy 2..13, no retrigger.
    rst_if.cpu_soft_rst_req = 2'b01;
    tick();
    check_eq("core_cause", 32'(rst_if.rst_cause), 32'h1);
    check_window("core", 2'b01, 1, 18, 2, 1'b1);
    rst_if.cpu_soft_rst_req = 2'b00;
    clear_cause();

    // Both bits at once: only a system pulse, no trailing core pulse.
    rst_if.cpu_soft_rst_req = 2'b11;
    tick();
    check_eq("both_cause", 32'(rst_if.rst_cause), 32'h3);
    check_window("both", 2'b10, 1, 20, 2, 1'b1);
    rst_if.cpu_soft_rst_req = 2'b00;
    clear_cause();

    // Three-cycle button glitch is ignored.
    rst_if.btn_rst_n = 1'b0;
    repeat (3) tick();
    rst_if.btn_rst_n = 1'b1;
    wait_pulse(30, cyc);
    check_eq("btn_glitch", 32'(cyc), 32'hFFFF_FFFF);
    check_eq("btn_glitch_cause", 32'(rst_if.rst_cause), 32'd0);

    // Stable press: sync 2 + debounce 5 + one-shot 1 + pend 1 + output 1 = 10 ticks.
    rst_if.btn_rst_n = 1'b0;
    wait_pulse(20, cyc);
    check_eq("btn_lat", 32'(cyc), 32'd10);
    check_eq("btn_kind", 32'(rst_if.soft_rst_out), 32'h2);
    check_eq("btn_cause", 32'(rst_if.rst_cause), 32'h8);
    wait_idle("btn_idle");
    wait_pulse(100, cyc);
    check_eq("btn_hold", 32'(cyc), 32'hFFFF_FFFF);
    rst_if.btn_rst_n = 1'b1;
    repeat (3) tick();
    clear_cause();

    // Watchdog serviced every 15 cycles never fires.
    rst_if.wdt_en   = 1'b1;
    rst_if.wdt_kick = 1'b1;
    tick();
    rst_if.wdt_kick = 1'b0;
    saw_pulse = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 14; i++) begin
        tick();
        if (rst_if.soft_rst_out != 2'b00) saw_pulse = 1'b1;
      end
      rst_if.wdt_kick = 1'b1;
      tick();
      rst_if.wdt_kick = 1'b0;
    end
    check_eq("wdt_kicked", 32'(saw_pulse), 32'd0);

    // Kicks stop: expiry 20 edges after the last reload, pulse 2 edges later.
    wait_pulse(40, cyc);
    check_eq("wdt_lat", 32'(cyc), 32'd22);
    check_eq("wdt_kind", 32'(rst_if.soft_rst_out), 32'h2);
    check_eq("wdt_cause", 32'(rst_if.rst_cause), 32'h4);
    wait_idle("wdt_idle");
    wait_pulse(60, cyc);
    check_eq("wdt_frozen", 32'(cyc), 32'hFFFF_FFFF);

    // Re-enable re-arms: counter held at 19 while disabled.
    rst_if.wdt_en = 1'b0;
    tick();
    rst_if.wdt_en = 1'b1;
    wait_pulse(40, cyc);
    check_eq("wdt_rearm_lat", 32'(cyc), 32'd22);
    rst_if.wdt_en = 1'b0;
    wait_idle("wdt_rearm_idle");
    clear_cause();

    // Core request at edge 8 (HOLDOFF) is serviced after return to IDLE; clear loses to set.
    rst_if.cpu_soft_rst_req = 2'b01;
    tick();
    rst_if.cpu_soft_rst_req = 2'b00;
    repeat (7) tick();
    rst_if.cpu_soft_rst_req = 2'b01;
    rst_if.cause_clr        = 1'b1;
    tick();
    rst_if.cpu_soft_rst_req = 2'b00;
    rst_if.cause_clr        = 1'b0;
    check_eq("clr_vs_set", 32'(rst_if.rst_cause), 32'h1);
    check_eq("holdoff_busy", 32'(rst_if.req_busy), 32'd1);
    check_window("busy2", 2'b01, 9, 22, 15, 1'b0);
    wait_idle("busy2_idle");
    clear_cause();

    // Power-on reset in the middle of a pulse.
    rst_if.cpu_soft_rst_req = 2'b01;
    tick();
    rst_if.cpu_soft_rst_req = 2'b00;
    repeat (3) tick();
    check_eq("por_mid", 32'(rst_if.soft_rst_out), 32'h1);
    mcu_rst_signal = 1'b0;
    #1;
    check_eq("por_out",   32'(rst_if.soft_rst_out), 32'd0);
    check_eq("por_cause", 32'(rst_if.rst_cause),    32'd0);
    check_eq("por_busy",  32'(rst_if.req_busy),     32'd0);
    @(negedge sys_clk);
    mcu_rst_signal = 1'b1;
    wait_pulse(40, cyc);
    check_eq("por_no_pulse", 32'(cyc), 32'hFFFF_FFFF);
    check_eq("por_cause_after", 32'(rst_if.rst_cause), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
